// File: rtl/mdu_pkg.sv
// Shared definitions for the mult/div unit issue path.
// Op codes 1-6 match the MDU's own MultDivOp encoding.
package mdu_pkg;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_RISE,
      ST_RUN
   } state_t;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_DIVU);
   endfunction

   function automatic logic is_mt(input logic [3:0] op);
      return (op == OP_MTHI) || (op == OP_MTLO);
   endfunction

   function automatic logic is_mdu_class(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_MFLO);
   endfunction

endpackage

// File: rtl/mdu_watchdog.sv
// Occupancy watchdog: counts cycles while the MDU is in flight
// and raises a sticky error when the limit is reached.
module mdu_watchdog #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic active,
   output logic fire,
   output logic err
);

   logic [CNT_W-1:0] wd;

   assign fire = active && (wd == CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         wd  <= '0;
         err <= 1'b0;
      end else begin
         if (clear)
            wd <= '0;
         else if (active && !fire)
            wd <= wd + CNT_W'(1);
         if (fire)
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issue controller: issues ops, tracks occupancy,
// stalls D on MDU-class ops and serves mfhi/mflo from shadows.
module mdu_issue_ctrl
   import mdu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        e_valid,
   input  logic [3:0]  e_op,
   input  logic [31:0] e_rs,
   input  logic [31:0] e_rt,
   input  logic        d_is_mdu,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_hi,
   input  logic [31:0] mdu_lo,
   output logic        mdu_start,
   output logic [3:0]  mdu_op,
   output logic        mdu_write,
   output logic [31:0] mdu_a,
   output logic [31:0] mdu_b,
   output logic        stall_d,
   output logic [31:0] rd_data,
   output logic        err
);

   state_t      state;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        idle;
   logic        fire;

   assign idle      = (state == ST_IDLE);
   assign mdu_start = idle & e_valid & is_muldiv(e_op) & ~req;
   assign mdu_write = idle & e_valid & is_mt(e_op) & ~req;
   assign mdu_op    = (is_muldiv(e_op) | is_mt(e_op)) ? e_op : 4'd0;
   assign mdu_a     = e_rs;
   assign mdu_b     = e_rt;
   assign stall_d   = d_is_mdu & (~idle | mdu_start);

   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         e_valid && (e_op == OP_MFHI): rd_data = hi_q;
         e_valid && (e_op == OP_MFLO): rd_data = lo_q;
         default:                      rd_data = '0;
      endcase
   end

   mdu_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wd (
      .clk    (clk),
      .reset  (reset),
      .clear  (mdu_start),
      .active (~idle),
      .fire   (fire),
      .err    (err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (mdu_start)
                  state <= ST_WAIT_RISE;
               if (mdu_write && e_op == OP_MTHI)
                  hi_q <= e_rs;
               if (mdu_write && e_op == OP_MTLO)
                  lo_q <= e_rs;
            end
            ST_WAIT_RISE: begin
               if (fire)
                  state <= ST_IDLE;
               else if (mdu_busy)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               // a timeout leaves the shadows untouched
               if (fire) begin
                  state <= ST_IDLE;
               end else if (!mdu_busy) begin
                  state <= ST_IDLE;
                  hi_q  <= mdu_hi;
                  lo_q  <= mdu_lo;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural MDU
// whose rise delay and busy length are chosen per operation.
module tb_mdu_issue_ctrl;

   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic        start;
      logic        write;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } iss_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        e_valid;
   logic [3:0]  e_op;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        d_is_mdu;
   logic        mdu_busy;
   logic [31:0] mdu_hi;
   logic [31:0] mdu_lo;
   logic        mdu_start;
   logic [3:0]  mdu_op;
   logic        mdu_write;
   logic [31:0] mdu_a;
   logic [31:0] mdu_b;
   logic        stall_d;
   logic [31:0] rd_data;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   iss_t        q_iss[$];
   logic [31:0] q_rd[$];
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   logic        stuck;
   int          cfg_delay;
   int          cfg_lat;
   logic        m_busy;
   logic        m_pend;
   int          m_wait;
   int          m_cnt;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [64:0] m_res;

   always #5 clk = ~clk;

   mdu_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .e_valid   (e_valid),
      .e_op      (e_op),
      .e_rs      (e_rs),
      .e_rt      (e_rt),
      .d_is_mdu  (d_is_mdu),
      .mdu_busy  (mdu_busy),
      .mdu_hi    (mdu_hi),
      .mdu_lo    (mdu_lo),
      .mdu_start (mdu_start),
      .mdu_op    (mdu_op),
      .mdu_write (mdu_write),
      .mdu_a     (mdu_a),
      .mdu_b     (mdu_b),
      .stall_d   (stall_d),
      .rd_data   (rd_data),
      .err       (err)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // {keep, hi, lo}; keep=1 means the MDU leaves HI/LO alone
   function automatic logic [64:0] calc(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub, p;
      logic [64:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r = {1'b1, 64'd0};
      case (op)
         4'd1: begin p = longint'(sa * sb); r = {1'b0, p}; end
         4'd2: begin p = ua * ub; r = {1'b0, p}; end
         4'd3: if (b != 0) r = {1'b0, 32'(sa % sb), 32'(sa / sb)};
         4'd4: if (b != 0) r = {1'b0, a % b, a / b};
         default: r = {1'b1, 64'd0};
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_pend <= 1'b0;
         m_wait <= 0;
         m_cnt  <= 0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_res  <= '0;
      end else begin
         if (mdu_start && !stuck) begin
            m_pend <= 1'b1;
            m_wait <= cfg_delay;
            m_res  <= calc(mdu_op, mdu_a, mdu_b);
         end else if (m_pend) begin
            if (m_wait == 0) begin
               m_busy <= 1'b1;
               m_cnt  <= cfg_lat - 1;
               m_pend <= 1'b0;
            end else begin
               m_wait <= m_wait - 1;
            end
         end else if (m_busy) begin
            if (m_cnt == 0) begin
               m_busy <= 1'b0;
               if (!m_res[64]) begin
                  m_hi <= m_res[63:32];
                  m_lo <= m_res[31:0];
               end
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
         if (mdu_write) begin
            if (mdu_op == 4'd5) m_hi <= mdu_a;
            else                m_lo <= mdu_a;
         end
      end
   end

   assign mdu_busy = m_busy;
   assign mdu_hi   = m_busy ? 32'd0 : m_hi;
   assign mdu_lo   = m_busy ? 32'd0 : m_lo;

   always @(negedge clk) begin
      if (!reset) begin
         if (mdu_start || mdu_write) begin
            if (q_iss.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_issue: got start=%b write=%b op=%0d expected none",
                        mdu_start, mdu_write, mdu_op);
            end else begin
               iss_t e;
               e = q_iss.pop_front();
               check("issue_start", 32'(mdu_start), 32'(e.start));
               check("issue_write", 32'(mdu_write), 32'(e.write));
               check("issue_op", 32'(mdu_op), 32'(e.op));
               check("issue_a", mdu_a, e.a);
               check("issue_b", mdu_b, e.b);
            end
         end
         if (e_valid && (e_op == 4'd7 || e_op == 4'd8)) begin
            if (q_rd.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_mf: got %h expected no read", rd_data);
            end else begin
               check("rd_data", rd_data, q_rd.pop_front());
            end
         end
      end
   end

   task automatic drive_idle();
      e_valid  = 1'b0;
      e_op     = 4'd0;
      req      = 1'b0;
      d_is_mdu = 1'b0;
   endtask

   task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int d, input int l,
                             input logic rq_mid, input logic stk);
      int stalls;
      int n;
      logic [64:0] r;
      @(posedge clk); #1;
      cfg_delay = d;
      cfg_lat   = l;
      stuck     = stk;
      e_valid   = 1'b1;
      e_op      = op;
      e_rs      = a;
      e_rt      = b;
      req       = 1'b0;
      d_is_mdu  = 1'b1;
      q_iss.push_back('{1'b1, 1'b0, op, a, b});
      @(negedge clk);
      check("start_stall", 32'(stall_d), 32'd1);
      stalls = stall_d ? 1 : 0;
      n = 0;
      while (n < 60) begin
         @(posedge clk); #1;
         // an MDU op in E while occupied must not issue
         e_valid = (n == 0);
         e_op    = (n == 0) ? 4'd3 : op;
         req     = rq_mid && (n == 2);
         @(negedge clk);
         if (n == 0) check("busy_no_rd", rd_data, 32'd0);
         n++;
         if (!stall_d) break;
         stalls++;
      end
      req = 1'b0;
      check("stall_cycles", 32'(stalls), stk ? 32'(TIMEOUT + 2) : 32'(d + l + 3));
      if (!stk) begin
         r = calc(op, a, b);
         if (!r[64]) begin
            exp_hi = r[63:32];
            exp_lo = r[31:0];
         end
      end
   endtask

   task automatic mf(input logic [3:0] op, input logic [31:0] exp);
      @(posedge clk); #1;
      e_valid  = 1'b1;
      e_op     = op;
      e_rs     = $urandom;
      req      = 1'b0;
      d_is_mdu = 1'($urandom_range(0, 1));
      q_rd.push_back(exp);
      @(negedge clk);
      check("mf_stall", 32'(stall_d), 32'd0);
      check("mf_op", 32'(mdu_op), 32'd0);
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic rq);
      @(posedge clk); #1;
      e_valid  = 1'b1;
      e_op     = op;
      e_rs     = a;
      e_rt     = $urandom;
      req      = rq;
      d_is_mdu = 1'($urandom_range(0, 1));
      if (!rq) begin
         q_iss.push_back('{1'b0, 1'b1, op, a, e_rt});
         if (op == 4'd5) exp_hi = a;
         else            exp_lo = a;
      end
      @(negedge clk);
      check("mt_stall", 32'(stall_d), 32'd0);
      check("mt_start", 32'(mdu_start), 32'd0);
      if (rq) check("mt_req_write", 32'(mdu_write), 32'd0);
   endtask

   task automatic req_muldiv(input logic [3:0] op);
      @(posedge clk); #1;
      e_valid  = 1'b1;
      e_op     = op;
      e_rs     = $urandom;
      e_rt     = $urandom;
      req      = 1'b1;
      d_is_mdu = 1'b1;
      @(negedge clk);
      check("req_start", 32'(mdu_start), 32'd0);
      check("req_stall", 32'(stall_d), 32'd0);
      @(posedge clk); #1;
      e_valid = 1'b0;
      req     = 1'b0;
      @(negedge clk);
      check("req_fsm_idle", 32'(stall_d), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          k;
      reset     = 1'b1;
      stuck     = 1'b0;
      cfg_delay = 0;
      cfg_lat   = 1;
      e_rs      = '0;
      e_rt      = '0;
      exp_hi    = '0;
      exp_lo    = '0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      d_is_mdu = 1'b1;
      @(negedge clk);
      check("rst_stall", 32'(stall_d), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rd", rd_data, 32'd0);
      check("rst_start", 32'(mdu_start), 32'd0);
      check("rst_write", 32'(mdu_write), 32'd0);
      mf(4'd7, 32'd0);

      run_muldiv(4'd1, -32'sd3, 32'd5, 0, 5, 1'b0, 1'b0);
      mf(4'd8, 32'hFFFF_FFF1);
      mf(4'd7, 32'hFFFF_FFFF);

      run_muldiv(4'd4, 32'd7, 32'd2, 1, 10, 1'b0, 1'b0);
      mf(4'd7, 32'd1);
      mf(4'd8, 32'd3);

      mt(4'd5, 32'hDEAD_BEEF, 1'b0);
      mf(4'd7, 32'hDEAD_BEEF);

      req_muldiv(4'd1);
      run_muldiv(4'd3, 32'd100, -32'sd7, 2, 9, 1'b1, 1'b0);
      mf(4'd8, exp_lo);
      mf(4'd7, exp_hi);

      run_muldiv(4'd3, 32'd5, 32'd0, 0, 9, 1'b0, 1'b0);
      mf(4'd7, exp_hi);
      mf(4'd8, exp_lo);

      check("pre_stuck_err", 32'(err), 32'd0);
      run_muldiv(4'd2, 32'd9, 32'd9, 0, 5, 1'b0, 1'b1);
      stuck = 1'b0;
      check("stuck_err", 32'(err), 32'd1);
      mf(4'd8, exp_lo);
      run_muldiv(4'd1, 32'd2, 32'd3, 0, 4, 1'b0, 1'b0);
      check("err_sticky", 32'(err), 32'd1);
      mf(4'd8, 32'd6);

      @(posedge clk); #1;
      cfg_delay = 0;
      cfg_lat   = 10;
      e_valid   = 1'b1;
      e_op      = 4'd1;
      e_rs      = 32'd11;
      e_rt      = 32'd13;
      d_is_mdu  = 1'b1;
      q_iss.push_back('{1'b1, 1'b0, 4'd1, 32'd11, 32'd13});
      @(negedge clk);
      repeat (4) begin
         @(posedge clk); #1;
         e_valid = 1'b0;
         @(negedge clk);
      end
      check("run_stall", 32'(stall_d), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      check("mid_rst_stall", 32'(stall_d), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      mf(4'd7, 32'd0);
      mf(4'd8, 32'd0);

      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 9);
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
         if (k <= 3) begin
            op = 4'(k + 1);
            run_muldiv(op, a, b, $urandom_range(0, 2),
                       (op <= 4'd2) ? $urandom_range(3, 6) : $urandom_range(8, 11),
                       1'($urandom_range(0, 1)), 1'b0);
         end else if (k <= 5) begin
            mt(4'(k + 1), a, 1'($urandom_range(0, 3) == 0));
         end else if (k == 6) begin
            mf(4'd7, exp_hi);
         end else if (k == 7) begin
            mf(4'd8, exp_lo);
         end else if (k == 8) begin
            @(posedge clk); #1;
            drive_idle();
            e_op = 4'($urandom_range(7, 8));
            @(negedge clk);
            check("invalid_rd", rd_data, 32'd0);
         end else begin
            req_muldiv(4'($urandom_range(1, 4)));
         end
      end

      @(posedge clk); #1;
      drive_idle();
      repeat (2) @(negedge clk);
      check("iss_drained", 32'(q_iss.size()), 32'd0);
      check("rd_drained", 32'(q_rd.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
